// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: command opcodes, responder state encoding and
// opcode classification helpers. Used by the responder and the SoC controller.
package qspi_pkg;

    localparam logic [7:0] OP_QUAD_READ  = 8'hEB;
    localparam logic [7:0] OP_QUAD_WRITE = 8'h38;
    localparam logic [7:0] OP_PAGE_PROG  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } qspi_state_e;

    function automatic logic is_read_op(input logic [7:0] op);
        return op == OP_QUAD_READ;
    endfunction

    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_QUAD_WRITE) || (op == OP_PAGE_PROG);
    endfunction

endpackage

// File: rtl/qspi_psram_responder_if.sv
// QSPI pin bundle plus backing-memory port of the PSRAM responder.
//   slave  : responder side (samples QSPI pins / mem_rdata, drives io_* and mem_*)
//   master : initiator + backing memory side
interface qspi_psram_responder_if #(
    parameter int unsigned ADDR_W = 24
) ();

    logic              sclk;
    logic              cs_n;
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport slave (
        input  sclk, cs_n, io_in, mem_rdata,
        output io_out, io_oe, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output sclk, cs_n, io_in, mem_rdata,
        input  io_out, io_oe, mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface

// File: rtl/qspi_sync_edge.sv
// Two-flop synchronizers for the QSPI pins and edge detection on the
// synchronized sclk / cs_n.
//   clk, rst         : system clock, async active-high reset
//   sclk, cs_n, io_in: raw QSPI pins (asynchronous to clk)
//   cs_n_s, io_s     : synchronized chip select and data nibble
//   sclk_rise_c      : one-clk pulse on synchronized sclk rising edge
//   sclk_fall_c      : one-clk pulse on synchronized sclk falling edge
//   cs_fall_c        : one-clk pulse on synchronized cs_n falling edge
module qspi_sync_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] io_in,
    output logic       cs_n_s,
    output logic [3:0] io_s,
    output logic       sclk_rise_c,
    output logic       sclk_fall_c,
    output logic       cs_fall_c
);

    logic       sclk_m;
    logic       sclk_s;
    logic       sclk_q;
    logic       cs_m;
    logic       cs_q;
    logic [3:0] io_m;

    // Synchronizer chains; reset to the bus idle levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_q <= 1'b0;
            cs_m   <= 1'b1;
            cs_n_s <= 1'b1;
            cs_q   <= 1'b1;
            io_m   <= 4'h0;
            io_s   <= 4'h0;
        end else begin
            sclk_m <= sclk;
            sclk_s <= sclk_m;
            sclk_q <= sclk_s;
            cs_m   <= cs_n;
            cs_n_s <= cs_m;
            cs_q   <= cs_n_s;
            io_m   <= io_in;
            io_s   <= io_m;
        end
    end

    assign sclk_rise_c = sclk_s & ~sclk_q;
    assign sclk_fall_c = ~sclk_s & sclk_q;
    assign cs_fall_c   = ~cs_n_s & cs_q;

endmodule

// File: rtl/qspi_psram_responder.sv
// Quad-SPI PSRAM responder: decodes quad read (EB) and quad write (38/02)
// transactions from an external initiator and turns them into byte accesses
// on an external backing memory.
//   clk, rst : system clock (>= 4x sclk), async active-high reset
//   bus      : QSPI pins (sclk, cs_n, io_in, io_out, io_oe) and memory port
//              (mem_addr, mem_wdata, mem_we, mem_re, mem_rdata; rdata valid
//              one clk after mem_re)
module qspi_psram_responder
    import qspi_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DUMMY_CYCLES = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    qspi_psram_responder_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DUMMY_LAST =
        CNT_W'((DUMMY_CYCLES == 0) ? 0 : DUMMY_CYCLES - 1);

    logic              cs_n_s;
    logic [3:0]        io_s;
    logic              sclk_rise_c;
    logic              sclk_fall_c;
    logic              cs_fall_c;

    qspi_state_e       state;
    logic [CNT_W-1:0]  nib_cnt;
    logic [3:0]        cmd_hi;
    logic [19:0]       addr_sh;
    logic [23:0]       addr_full_c;
    logic              is_read;
    logic              half;
    logic [3:0]        wr_hi;
    logic              rd_pend;
    logic [7:0]        tx;

    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;

    qspi_sync_edge u_sync (
        .clk         (clk),
        .rst         (rst),
        .sclk        (bus.sclk),
        .cs_n        (bus.cs_n),
        .io_in       (bus.io_in),
        .cs_n_s      (cs_n_s),
        .io_s        (io_s),
        .sclk_rise_c (sclk_rise_c),
        .sclk_fall_c (sclk_fall_c),
        .cs_fall_c   (cs_fall_c)
    );

    // Full 24-bit address as it stands after the current nibble.
    assign addr_full_c = {addr_sh, io_s};

    // Transaction FSM with registered pin and memory outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            nib_cnt   <= '0;
            cmd_hi    <= 4'h0;
            addr_sh   <= '0;
            is_read   <= 1'b0;
            half      <= 1'b0;
            wr_hi     <= 4'h0;
            rd_pend   <= 1'b0;
            tx        <= 8'h00;
            io_out    <= 4'h0;
            io_oe     <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            // Read data arrives one clk after the mem_re pulse.
            rd_pend <= mem_re;
            if (rd_pend) begin
                tx <= bus.mem_rdata;
            end
            // Post-write increment keeps mem_addr stable during the mem_we pulse.
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end

            if (cs_n_s) begin
                state   <= ST_IDLE;
                io_oe   <= 4'h0;
                nib_cnt <= '0;
                half    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall_c) begin
                            state   <= ST_CMD;
                            nib_cnt <= '0;
                            half    <= 1'b0;
                        end
                    end

                    ST_CMD: begin
                        if (sclk_rise_c) begin
                            cmd_hi  <= io_s;
                            nib_cnt <= nib_cnt + CNT_W'(1);
                            if (nib_cnt == CNT_W'(1)) begin
                                nib_cnt <= '0;
                                if (is_read_op({cmd_hi, io_s})) begin
                                    is_read <= 1'b1;
                                    state   <= ST_ADDR;
                                end else if (is_write_op({cmd_hi, io_s})) begin
                                    is_read <= 1'b0;
                                    state   <= ST_ADDR;
                                end else begin
                                    state   <= ST_IGNORE;
                                end
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (sclk_rise_c) begin
                            addr_sh <= addr_full_c[19:0];
                            nib_cnt <= nib_cnt + CNT_W'(1);
                            if (nib_cnt == CNT_W'(5)) begin
                                nib_cnt  <= '0;
                                mem_addr <= ADDR_W'(addr_full_c);
                                if (is_read) begin
                                    mem_re <= 1'b1;
                                    if (DUMMY_CYCLES == 0) begin
                                        state <= ST_RDATA;
                                        io_oe <= 4'hF;
                                        half  <= 1'b0;
                                    end else begin
                                        state <= ST_DUMMY;
                                    end
                                end else begin
                                    state <= ST_WDATA;
                                    half  <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_DUMMY: begin
                        if (sclk_rise_c) begin
                            nib_cnt <= nib_cnt + CNT_W'(1);
                            if (nib_cnt == DUMMY_LAST) begin
                                nib_cnt <= '0;
                                state   <= ST_RDATA;
                                io_oe   <= 4'hF;
                                half    <= 1'b0;
                            end
                        end
                    end

                    ST_RDATA: begin
                        io_oe <= 4'hF;
                        if (sclk_fall_c) begin
                            if (!half) begin
                                io_out <= tx[7:4];
                                half   <= 1'b1;
                            end else begin
                                // Prefetch the next byte while the low nibble is on the bus.
                                io_out   <= tx[3:0];
                                half     <= 1'b0;
                                mem_addr <= mem_addr + ADDR_W'(1);
                                mem_re   <= 1'b1;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (sclk_rise_c) begin
                            if (!half) begin
                                wr_hi <= io_s;
                                half  <= 1'b1;
                            end else begin
                                mem_wdata <= {wr_hi, io_s};
                                mem_we    <= 1'b1;
                                half      <= 1'b0;
                            end
                        end
                    end

                    ST_IGNORE: begin
                        io_oe <= 4'h0;
                    end

                    default: begin
                        state <= ST_IDLE;
                        io_oe <= 4'h0;
                    end
                endcase
            end
        end
    end

    assign bus.io_out    = io_out;
    assign bus.io_oe     = io_oe;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_we    = mem_we;
    assign bus.mem_re    = mem_re;

endmodule

// File: tb/tb_qspi_psram_responder.sv
// Bench for qspi_psram_responder: table of write transactions plus
// hand-written read, ignore, partial-write and reset-abort sequences.
module tb_qspi_psram_responder;

    logic clk;
    logic rst;

    qspi_psram_responder_if #(.ADDR_W(24)) bus ();

    qspi_psram_responder #(
        .ADDR_W       (24),
        .DUMMY_CYCLES (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [23:0] ea0;
        logic [23:0] ea1;
    } wvec_t;

    wr_t        wlog[$];
    logic [7:0] mem8 [256];
    int         rd_cnt;
    int         collide;
    logic       oe_seen;
    int         n_chk;
    int         n_err;

    // Backing memory and bus monitor.
    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_rdata <= mem8[bus.mem_addr[7:0]];
            rd_cnt = rd_cnt + 1;
        end
        if (bus.mem_we) wlog.push_back(wr_t'{bus.mem_addr, bus.mem_wdata});
        if (bus.mem_re && bus.mem_we) collide = collide + 1;
        if (bus.io_oe != 4'h0) oe_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One sclk period: drive nibble, sample responder pins just before the rise.
    task automatic clk_nib(input logic [3:0] n, output logic [3:0] got, output logic [3:0] oe);
        bus.io_in = n;
        #50;
        got = bus.io_out;
        oe  = bus.io_oe;
        bus.sclk = 1'b1;
        #50;
        bus.sclk = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] n);
        logic [3:0] g;
        logic [3:0] o;
        clk_nib(n, g, o);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
        bus.cs_n = 1'b0;
        #100;
        send_nib(op[7:4]);
        send_nib(op[3:0]);
        for (int i = 5; i >= 0; i--) send_nib(addr[i*4 +: 4]);
    endtask

    task automatic end_txn();
        #50;
        bus.cs_n = 1'b1;
        #200;
    endtask

    task automatic clear_mon();
        wlog.delete();
        rd_cnt  = 0;
        oe_seen = 1'b0;
    endtask

    task automatic check_wlog(input string tag, input int k, input logic [23:0] ea, input logic [7:0] ed);
        if (k < wlog.size()) begin
            check($sformatf("%s_addr%0d", tag, k), 32'(wlog[k].addr), 32'(ea));
            check($sformatf("%s_data%0d", tag, k), 32'(wlog[k].data), 32'(ed));
        end
    endtask

    wvec_t      wv [3];
    logic [3:0] got;
    logic [3:0] oe;
    logic [3:0] oe_acc;
    logic [3:0] exp_nib [4];

    initial begin
        n_chk   = 0;
        n_err   = 0;
        collide = 0;
        clear_mon();
        rst        = 1'b1;
        bus.sclk   = 1'b0;
        bus.cs_n   = 1'b1;
        bus.io_in  = 4'h0;

        wv[0] = '{op: 8'h38, addr: 24'h000010, d0: 8'hA5, d1: 8'h3C, ea0: 24'h000010, ea1: 24'h000011};
        wv[1] = '{op: 8'h02, addr: 24'h000020, d0: 8'h12, d1: 8'h34, ea0: 24'h000020, ea1: 24'h000021};
        wv[2] = '{op: 8'h38, addr: 24'hFFFFFF, d0: 8'h5A, d1: 8'hC3, ea0: 24'hFFFFFF, ea1: 24'h000000};

        mem8[8'h10] = 8'hA5;
        mem8[8'h11] = 8'h3C;
        mem8[8'h12] = 8'h96;
        exp_nib[0] = 4'hA;
        exp_nib[1] = 4'h5;
        exp_nib[2] = 4'h3;
        exp_nib[3] = 4'hC;

        // Reset values
        #20;
        check("rst_io_oe",     32'(bus.io_oe),     32'h0);
        check("rst_io_out",    32'(bus.io_out),    32'h0);
        check("rst_mem_we",    32'(bus.mem_we),    32'h0);
        check("rst_mem_re",    32'(bus.mem_re),    32'h0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        #30;
        rst = 1'b0;
        #100;

        // Table-driven write transactions
        for (int i = 0; i < 3; i++) begin
            clear_mon();
            send_hdr(wv[i].op, wv[i].addr);
            send_nib(wv[i].d0[7:4]);
            send_nib(wv[i].d0[3:0]);
            send_nib(wv[i].d1[7:4]);
            send_nib(wv[i].d1[3:0]);
            end_txn();
            check($sformatf("wr%0d_count", i), 32'(wlog.size()), 32'd2);
            check($sformatf("wr%0d_no_re", i), 32'(rd_cnt), 32'd0);
            check($sformatf("wr%0d_no_oe", i), 32'(oe_seen), 32'd0);
            check_wlog($sformatf("wr%0d", i), 0, wv[i].ea0, wv[i].d0);
            check_wlog($sformatf("wr%0d", i), 1, wv[i].ea1, wv[i].d1);
        end

        // Quad read at 0x10: 6 dummy cycles then A,5,3,C
        clear_mon();
        send_hdr(8'hEB, 24'h000010);
        oe_acc = 4'h0;
        for (int i = 0; i < 6; i++) begin
            clk_nib(4'h0, got, oe);
            oe_acc = oe_acc | oe;
        end
        check("rd_dummy_oe", 32'(oe_acc), 32'h0);
        for (int i = 0; i < 4; i++) begin
            clk_nib(4'h0, got, oe);
            check($sformatf("rd_nib%0d", i), 32'(got), 32'(exp_nib[i]));
            check($sformatf("rd_oe%0d", i), 32'(oe), 32'hF);
        end
        end_txn();
        check("rd_oe_after_cs", 32'(bus.io_oe), 32'h0);
        check("rd_re_count", 32'(rd_cnt), 32'd3);
        check("rd_no_we", 32'(wlog.size()), 32'd0);

        // Unknown opcode 0x9F followed by 10 nibbles
        clear_mon();
        bus.cs_n = 1'b0;
        #100;
        send_nib(4'h9);
        send_nib(4'hF);
        for (int i = 0; i < 10; i++) send_nib(4'(i + 3));
        end_txn();
        check("ign_no_re", 32'(rd_cnt), 32'd0);
        check("ign_no_we", 32'(wlog.size()), 32'd0);
        check("ign_no_oe", 32'(oe_seen), 32'd0);

        // Following read behaves normally (addr 0x11 -> 3,C)
        send_hdr(8'hEB, 24'h000011);
        for (int i = 0; i < 6; i++) send_nib(4'h0);
        clk_nib(4'h0, got, oe);
        check("post_ign_nib0", 32'(got), 32'h3);
        clk_nib(4'h0, got, oe);
        check("post_ign_nib1", 32'(got), 32'hC);
        check("post_ign_oe", 32'(oe), 32'hF);
        end_txn();

        // cs_n raised after 3 write-data nibbles: half byte dropped
        clear_mon();
        send_hdr(8'h38, 24'h000040);
        send_nib(4'h1);
        send_nib(4'h2);
        send_nib(4'h3);
        end_txn();
        check("part_count", 32'(wlog.size()), 32'd1);
        check_wlog("part", 0, 24'h000040, 8'h12);

        // Reset pulse mid-read
        clear_mon();
        send_hdr(8'hEB, 24'h000010);
        for (int i = 0; i < 6; i++) send_nib(4'h0);
        clk_nib(4'h0, got, oe);
        check("rstrd_nib0", 32'(got), 32'hA);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstrd_oe", 32'(bus.io_oe), 32'h0);
        #4;
        bus.cs_n = 1'b1;
        #100;
        rst = 1'b0;
        #100;
        check("rstrd_no_we", 32'(wlog.size()), 32'd0);

        // Fresh transaction after reset
        clear_mon();
        send_hdr(8'h02, 24'h000050);
        send_nib(4'h7);
        send_nib(4'h7);
        send_nib(4'h8);
        send_nib(4'h8);
        end_txn();
        check("post_rst_count", 32'(wlog.size()), 32'd2);
        check_wlog("post_rst", 0, 24'h000050, 8'h77);
        check_wlog("post_rst", 1, 24'h000051, 8'h88);

        check("re_we_collision", 32'(collide), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/qspi_psram_responder.md
QSPI_PSRAM_RESPONDER -- requirements
Module: qspi_psram_responder

Interface
REQ-001 SHALL expose parameters: ADDR_W, 24, byte-address width to backing memory; DUMMY_CYCLES, 6, SCLK cycles between the last address nibble and the first read nibble.
REQ-002 SHALL have ports: clk in 1 system clock; rst in 1 reset, asynchronous, active-high.
REQ-003 SHALL have ports: sclk in 1 QSPI clock, asynchronous to clk; cs_n in 1 chip select, active-low.
REQ-004 SHALL have ports: io_in in 4 QSPI data from initiator; io_out out 4 data to initiator; io_oe out 4 per-bit output enable.
REQ-005 SHALL have ports: mem_addr out ADDR_W byte address; mem_wdata out 8; mem_we out 1; mem_re out 1; mem_rdata in 8, valid exactly one clk after mem_re.

Function
REQ-006 SHALL pass sclk, cs_n and io_in through 2-flop synchronizers; all decoding uses the synchronized copies. clk SHALL be at least 4x the sclk frequency.
REQ-007 SHALL detect the sclk rising edge (sample) and falling edge (drive) from the synchronized sclk and its previous value.
REQ-008 SHALL implement states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-009 IDLE -> CMD on synchronized cs_n falling; nibble counter cleared.
REQ-010 CMD SHALL shift 2 nibbles on rising edges, MSB nibble first; then 0xEB -> ADDR(read), 0x38 or 0x02 -> ADDR(write), any other value -> IGNORE.
REQ-011 ADDR SHALL shift 6 nibbles (24 bits, MSB first); bits above ADDR_W are discarded. After the 6th nibble: read -> DUMMY, write -> WDATA.
REQ-012 On entry to DUMMY, mem_re SHALL pulse one clk at the received address; the returned byte is latched into a tx register.
REQ-013 DUMMY SHALL count DUMMY_CYCLES rising edges, then enter RDATA; DUMMY_CYCLES=0 enters RDATA immediately.
REQ-014 RDATA: io_oe=4'hF; on each falling edge io_out SHALL present the tx high nibble, then on the next falling edge the low nibble.
REQ-015 RDATA: on the falling edge that drives a low nibble, the address SHALL increment and mem_re pulse, so the next byte is ready before its high nibble.
REQ-016 WDATA SHALL assemble 2 nibbles (high first) per byte; on the second, mem_we SHALL pulse one clk with mem_addr = current address, then the address increments.
REQ-017 Address increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-018 IGNORE SHALL keep io_oe=0 and ignore sclk until cs_n deasserts.
REQ-019 Synchronized cs_n high in any state SHALL force IDLE in the same clk: io_oe=0, counters cleared, partial write byte discarded, no mem_we.
REQ-020 mem_re and mem_we SHALL never be asserted in the same clk.
REQ-021 io_oe SHALL be 0 in every state except RDATA.

Reset
REQ-022 While rst=1: state=IDLE, io_oe=0, io_out=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, synchronizers = idle levels (sclk=0, cs_n=1).
REQ-023 Reset asserted mid-transaction SHALL abort it with no memory write; after release, the first cs_n falling edge starts a fresh CMD.

Structure
REQ-024 Command opcodes (0xEB, 0x38, 0x02) and the state enum SHALL live in shared package qspi_pkg, also used by the SoC QSPI controller.
REQ-025 Synchronizer plus edge detector SHALL be one sub-module, qspi_sync_edge. Backing memory SHALL stay outside this block.

Verification
REQ-026 Write 0x38, addr 0x000010, data 0xA5,0x3C -> mem_we pulses twice: (0x000010, 0xA5), (0x000011, 0x3C).
REQ-027 Read 0xEB, addr 0x000010, 6 dummy, 4 nibbles with memory preloaded -> io_in at initiator reads A,5,3,C; io_oe=F only during data.
REQ-028 Write at addr 0xFFFFFF (ADDR_W=24), 2 bytes -> second write at 0x000000.
REQ-029 Opcode 0x9F followed by 10 nibbles -> no mem_re/mem_we, io_oe stays 0; next 0xEB transaction behaves normally.
REQ-030 cs_n raised after 3 write-data nibbles -> exactly one mem_we, and the half byte is discarded; rst pulse mid-read -> io_oe=0 next clk.
REQ-031 Run SoC firmware boot from flash plus PSRAM load/store through the SoC top with this block as the PSRAM -> bit-identical memory contents vs behavioral model.
